// File: rtl/mat_mult_pkg.sv
// Shared types and constants for the sequential signed matrix multiplier.
package mat_mult_pkg;

    localparam int DATA_W     = 16;
    localparam int ACC_W      = 32;
    localparam int DEF_ROWS_A = 16;
    localparam int DEF_COLS_A = 49;
    localparam int DEF_COLS_B = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_mult_mac.sv
// 16x16 signed multiply feeding a 32-bit wrapping accumulator.
// The accumulator has a synchronous clear and an asynchronous reset.
module mat_mult_mac
    import mat_mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc_sum
);

    logic signed [ACC_W-1:0] prod_s;
    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    // Product and next accumulator value; sum wraps modulo 2^32.
    always_comb begin
        prod_s = ACC_W'($signed(a)) * ACC_W'($signed(b));
        sum_s  = acc_q + prod_s;
        if (clr) begin
            acc_d = {ACC_W{1'b0}};
        end else if (en) begin
            acc_d = sum_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= {ACC_W{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_sum = sum_s;

endmodule

// File: rtl/mat_mult_1632.sv
// Sequential C = A x B controller: one MAC per cycle, C written in row-major
// order through a synchronous-write port, done raised after the last write.
module mat_mult_1632
    import mat_mult_pkg::*;
#(
    parameter int ROWS_A = DEF_ROWS_A,
    parameter int COLS_A = DEF_COLS_A,
    parameter int COLS_B = DEF_COLS_B,
    parameter int AW_A   = $clog2(ROWS_A * COLS_A),
    parameter int AW_B   = $clog2(COLS_A * COLS_B),
    parameter int AW_C   = $clog2(ROWS_A * COLS_B)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [AW_A-1:0]   addr_a,
    input  logic [DATA_W-1:0] data_a,
    output logic [AW_B-1:0]   addr_b,
    input  logic [DATA_W-1:0] data_b,
    output logic [AW_C-1:0]   addr_c,
    output logic [ACC_W-1:0]  data_c,
    output logic              we_c,
    output logic              done
);

    localparam int IW = cnt_w(ROWS_A);
    localparam int KW = cnt_w(COLS_A);
    localparam int JW = cnt_w(COLS_B);
    localparam logic [IW-1:0] I_LAST = IW'(ROWS_A - 1);
    localparam logic [KW-1:0] K_LAST = KW'(COLS_A - 1);
    localparam logic [JW-1:0] J_LAST = JW'(COLS_B - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     i_q, i_d;
    logic [JW-1:0]     j_q, j_d;
    logic [KW-1:0]     k_q, k_d;
    logic              mac_clr_s;
    logic              mac_en_s;
    logic [ACC_W-1:0]  acc_sum_s;
    logic [AW_A-1:0]   addr_a_q, addr_a_d;
    logic [AW_B-1:0]   addr_b_q, addr_b_d;
    logic [AW_C-1:0]   addr_c_q, addr_c_d;
    logic [ACC_W-1:0]  data_c_q, data_c_d;
    logic              we_c_q, we_c_d;
    logic              done_q, done_d;

    mat_mult_mac u_mac (
        .clk     (clk),
        .rst     (reset),
        .clr     (mac_clr_s),
        .en      (mac_en_s),
        .a       (data_a),
        .b       (data_b),
        .acc_sum (acc_sum_s)
    );

    // Next-state and loop-counter logic.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        mac_clr_s = 1'b0;
        mac_en_s  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = CALC;
                    i_d       = {IW{1'b0}};
                    j_d       = {JW{1'b0}};
                    k_d       = {KW{1'b0}};
                    mac_clr_s = 1'b1;
                end else begin
                    state_d   = state_q;
                end
            end
            CALC: begin
                mac_en_s = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = WRITE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            WRITE: begin
                mac_clr_s = 1'b1;
                k_d       = {KW{1'b0}};
                if (j_q == J_LAST) begin
                    j_d = {JW{1'b0}};
                    i_d = i_q + IW'(1);
                end else begin
                    j_d = j_q + JW'(1);
                end
                if ((i_q == I_LAST) && (j_q == J_LAST)) begin
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so each CALC cycle already
    // presents its own operand addresses and WRITE presents the finished sum.
    always_comb begin
        addr_a_d = {AW_A{1'b0}};
        addr_b_d = {AW_B{1'b0}};
        addr_c_d = {AW_C{1'b0}};
        data_c_d = {ACC_W{1'b0}};
        we_c_d   = (state_d == WRITE);
        done_d   = (state_d == DONE);
        if (state_d == CALC) begin
            addr_a_d = AW_A'(int'(i_d) * COLS_A + int'(k_d));
            addr_b_d = AW_B'(int'(k_d) * COLS_B + int'(j_d));
        end else if (state_d == WRITE) begin
            addr_c_d = AW_C'(int'(i_d) * COLS_B + int'(j_d));
            data_c_d = acc_sum_s;
        end else begin
            addr_a_d = {AW_A{1'b0}};
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            i_q      <= {IW{1'b0}};
            j_q      <= {JW{1'b0}};
            k_q      <= {KW{1'b0}};
            addr_a_q <= {AW_A{1'b0}};
            addr_b_q <= {AW_B{1'b0}};
            addr_c_q <= {AW_C{1'b0}};
            data_c_q <= {ACC_W{1'b0}};
            we_c_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            addr_c_q <= addr_c_d;
            data_c_q <= data_c_d;
            we_c_q   <= we_c_d;
            done_q   <= done_d;
        end
    end

    assign addr_a = addr_a_q;
    assign addr_b = addr_b_q;
    assign addr_c = addr_c_q;
    assign data_c = data_c_q;
    assign we_c   = we_c_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mat_mult_1632.sv
// Scoreboard bench for mat_mult_1632: golden C computed by plain loops over
// the operand memories, compared against every C write in issue order.
module tb_mat_mult_1632;

    localparam int RA = 16;
    localparam int CA = 49;
    localparam int CB = 32;
    localparam int NC = RA * CB;

    logic        clk;
    logic        reset;
    logic        start;
    logic [9:0]  addr_a;
    logic [15:0] data_a;
    logic [10:0] addr_b;
    logic [15:0] data_b;
    logic [8:0]  addr_c;
    logic [31:0] data_c;
    logic        we_c;
    logic        done;

    logic signed [15:0] mem_a [0:RA*CA-1];
    logic signed [15:0] mem_b [0:CA*CB-1];
    logic        [31:0] mem_c [0:NC-1];

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;

    mat_mult_1632 dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .addr_a (addr_a),
        .data_a (data_a),
        .addr_b (addr_b),
        .data_b (data_b),
        .addr_c (addr_c),
        .data_c (data_c),
        .we_c   (we_c),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign data_a = mem_a[addr_a];
    assign data_b = mem_b[addr_b];

    always @(posedge clk) begin
        if (we_c) mem_c[addr_c] <= data_c;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Golden C[i][j] = sum_k A[i][k]*B[k][j] mod 2^32, pushed in row-major order.
    task automatic push_expected();
        exp_t e;
        longint s;
        for (int i = 0; i < RA; i++) begin
            for (int j = 0; j < CB; j++) begin
                s = 0;
                for (int k = 0; k < CA; k++)
                    s += longint'(mem_a[i*CA+k]) * longint'(mem_b[k*CB+j]);
                e.addr = 9'(i*CB + j);
                e.data = s[31:0];
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: every C write must match the next expected element.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && we_c) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", addr_c, data_c);
            end else begin
                e = exp_q.pop_front();
                check("c_addr", {55'd0, addr_c}, {55'd0, e.addr});
                check("c_data", {32'd0, data_c}, {32'd0, e.data});
            end
        end
    end

    task automatic fill_random(input bit do_a, input bit do_b);
        for (int n = 0; n < RA*CA; n++)
            if (do_a) mem_a[n] = 16'(int'($urandom_range(46)) - 23);
        for (int n = 0; n < CA*CB; n++)
            if (do_b) mem_b[n] = 16'(int'($urandom_range(46)) - 23);
    endtask

    // Cycles counted from the cycle start is high (1) to the first cycle done is high.
    task automatic do_run(input string tag, input int mid_start_at, input bit chk_time);
        int cycles;
        wr_cnt = 0;
        push_expected();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cycles = 1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_low"}, {63'd0, done}, 64'd0);
        while (!done && cycles < 30000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            start = (cycles == mid_start_at);
        end
        start = 1'b0;
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        if (chk_time) check({tag, "_cycles"}, 64'(cycles), 64'(RA*CB*(CA+1) + 1));
        check({tag, "_writes"}, 64'(wr_cnt), 64'(NC));
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int n = 0; n < RA*CA; n++) mem_a[n] = 16'd0;
        for (int n = 0; n < CA*CB; n++) mem_b[n] = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {30'd0, addr_a, addr_b, addr_c, we_c, done},
              64'd0);
        check("reset_data_c", {32'd0, data_c}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Random operands, timing, start pulse mid-run ignored.
        fill_random(1'b1, 1'b1);
        do_run("rand", 5000, 1'b1);

        // Back-to-back from DONE: identity A, negative-ramp B.
        for (int i = 0; i < RA; i++)
            for (int k = 0; k < CA; k++)
                mem_a[i*CA+k] = (k == i) ? 16'sd1 : 16'sd0;
        for (int k = 0; k < CA; k++)
            for (int j = 0; j < CB; j++)
                mem_b[k*CB+j] = 16'(-(k*CB + j));
        do_run("ident", -1, 1'b0);
        for (int n = 0; n < NC; n += 73)
            check("ident_c", {32'd0, mem_c[n]}, {32'd0, 32'(-n)});
        check("ident_c_last", {32'd0, mem_c[NC-1]}, {32'd0, 32'(-(NC-1))});

        // Reset roughly 1000 cycles into a run, then verify it stays quiet.
        fill_random(1'b0, 1'b1);
        push_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (998) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_outputs", {30'd0, addr_a, addr_b, addr_c, we_c, done}, 64'd0);
        check("midreset_data_c", {32'd0, data_c}, 64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check("idle_after_reset_done", {63'd0, done}, 64'd0);
        check("idle_after_reset_addr_a", {54'd0, addr_a}, 64'd0);

        // Restart after reset with extreme operands: every product is 2^30.
        for (int n = 0; n < RA*CA; n++) mem_a[n] = 16'h8000;
        for (int n = 0; n < CA*CB; n++) mem_b[n] = 16'h8000;
        do_run("ovf", -1, 1'b0);
        check("ovf_c_first", {32'd0, mem_c[0]}, {32'd0, 32'h4000_0000});
        check("ovf_c_last", {32'd0, mem_c[NC-1]}, {32'd0, 32'h4000_0000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
